pod_kinematics_integrator: RTL and testbench
============================================

Name: pod_kinematics_integrator

Overview:
Parametrised single-axis pod dynamics model for the HIL rig.
- Integrates a stream of signed fixed-point acceleration samples into velocity and position using semi-implicit Euler.
- Sits between the sensor-stimulus generator and the emulated sensor outputs.
- Adds over the first-generation pod model: a sample handshake, state load, freeze mode, saturation, and track-end/start clamping.

Parameters:
DATA_W, 32, width of accel/velocity/position words (signed two's complement)
FRAC_W, 16, fractional bits of all three quantities (same Q format)
DT_NUM, 21475, timestep numerator; dt = DT_NUM / 2^DT_SHIFT seconds
DT_SHIFT, 32, timestep shift (defaults give dt ≈ 5 µs)
TRACK_LEN, 32'h0640_0000, position upper limit in Q format (default 1600.0 m)

Ports:
clk_200khz  in   1       system clock
rst         in   1       synchronous, active-high reset
accel_valid in   1       accel sample offered
accel_ready out  1       block can accept a sample
accel       in   DATA_W  signed acceleration, m/s^2
run_en      in   1       1 = integrate; 0 = freeze (samples consumed, state held)
load        in   1       one-cycle strobe: load state
load_pos    in   DATA_W  position loaded on load
load_vel    in   DATA_W  velocity loaded on load
position    out  DATA_W  registered position, m
velocity    out  DATA_W  registered velocity, m/s
out_valid   out  1       one-cycle pulse: position/velocity updated for last sample
sat_flag    out  1       sticky: a result was clipped to the signed DATA_W range
at_end      out  1       sticky: position reached TRACK_LEN

Behaviour:
Clock and reset:
- One clock, clk_200khz.
- rst is synchronous and active-high.

Reset values:
- position = 0, velocity = 0, out_valid = 0, sat_flag = 0, at_end = 0, accel_ready = 0 while rst is high.
- The FSM enters IDLE after reset.

FSM states: IDLE -> MUL_V -> ADD_V -> MUL_P -> ADD_P -> IDLE.
- IDLE: accel_ready = ~load. A transfer occurs when accel_valid & accel_ready; accel is captured and the FSM goes to MUL_V. accel_ready is 0 in every other state.
- MUL_V: dv = (accel * DT_NUM) >>> DT_SHIFT. Full-precision product of DATA_W+32 bits; arithmetic shift truncates toward -inf.
- ADD_V: v_new = sat(velocity + dv).
- MUL_P: dp = (v_new * DT_NUM) >>> DT_SHIFT, same rules as MUL_V.
- ADD_P: p_new = sat(position + dp), then the clamps below are applied. position and velocity are committed; out_valid = 1 for exactly this cycle; the FSM returns to IDLE.

Latency and throughput:
- Handshake in cycle N gives out_valid in cycle N+4.
- Next accept is no earlier than N+5; maximum rate is 1 sample per 5 cycles.

Arithmetic rules:
- sat() clips to [-2^(DATA_W-1), 2^(DATA_W-1)-1] and sets sat_flag.

Clamps, applied in ADD_P in this order:
- If p_new >= TRACK_LEN: position = TRACK_LEN, velocity = 0, at_end = 1.
- Else if p_new < 0: position = 0, and velocity = 0 if v_new < 0.
- While at_end = 1, positive v_new is forced to 0; position stays at TRACK_LEN.

Freeze mode:
- run_en is sampled at the accept cycle.
- If run_en = 0, the FSM still runs and pulses out_valid at N+4, but commits the unchanged position and velocity. No flags change.

Load:
- Accepted in any state.
- Next cycle: position = load_pos, velocity = load_vel, sat_flag = 0, at_end = 0, FSM = IDLE.
- An in-flight sample is discarded and produces no out_valid.
- load and accel_valid together in IDLE: load wins and the sample is not accepted (accel_ready = 0).
- Loaded values are not clamped.

Reset mid-operation:
- Identical to the reset values above. The in-flight sample is dropped and produces no out_valid.

Decomposition:
- Shared package pod_model_pkg holds:
  - the Q-format constants (DATA_W, FRAC_W defaults);
  - the FSM state typedef (IDLE, MUL_V, ADD_V, MUL_P, ADD_P);
  - the saturating-add function.
- One sub-module, pod_fx_scale: registered signed (x * DT_NUM) >>> DT_SHIFT.
  - Instantiated once and time-shared between the velocity and position steps.

Test Plan:
Bench overrides: DT_NUM=1, DT_SHIFT=4 (dt = 1/16 s), DATA_W=32, FRAC_W=16.
1. Reset, then accel=0x0010_0000 (16.0) accepted at cycle N -> out_valid only at N+4; velocity=0x0001_0000; position=0x0000_1000; accel_ready low for N+1..N+4.
2. Three back-to-back samples of 0x0010_0000 with accel_valid held high -> accepts 5 cycles apart; velocity 1.0, 2.0, 3.0; position 0x1000, 0x3000, 0x6000.
3. load_pos=0x063F_F000, load_vel=0x0010_0000, then accel=0 -> position=TRACK_LEN, velocity=0, at_end=1; a further positive accel keeps velocity=0.
4. load_vel=0x7FFF_FFF0, accel=0x7FFF_0000 -> velocity=0x7FFF_FFFF, sat_flag=1; a subsequent load clears sat_flag.
5. run_en=0 with accel=0x0010_0000 -> out_valid pulses at N+4; position and velocity unchanged.
6. load asserted in the MUL_P cycle -> no out_valid; next cycle position=load_pos, accel_ready=1. Repeat the test with rst in ADD_V -> all outputs 0.

Source files
------------

// File: rtl/pod_model_pkg.sv
// -----------------------------------------------------------------------------
// pod_model_pkg
// Shared definitions for the pod kinematics model:
//   - default Q-format widths for accel / velocity / position words
//   - FSM state encoding of the integrator sequence
//   - saturating signed add used for the velocity and position updates
// -----------------------------------------------------------------------------
package pod_model_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int FRAC_W_DEF = 16;

  // Working width of the saturating adder; any DATA_W up to SAT_W-1 fits.
  localparam int SAT_W = 64;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MUL_V = 3'd1,
    ADD_V = 3'd2,
    MUL_P = 3'd3,
    ADD_P = 3'd4
  } pod_state_e;

  typedef struct packed {
    logic                    clipped;
    logic signed [SAT_W-1:0] val;
  } sat_res_t;

  // a + b clipped to the signed range of a w-bit word. Operands arrive
  // sign-extended to SAT_W bits; the sum is formed one bit wider so it can
  // never wrap before the range test.
  function automatic sat_res_t sat_add(input logic signed [SAT_W-1:0] a,
                                       input logic signed [SAT_W-1:0] b,
                                       input int unsigned             w);
    logic signed [SAT_W:0] sum;
    logic signed [SAT_W:0] one;
    logic signed [SAT_W:0] hi;
    logic signed [SAT_W:0] lo;
    sat_res_t              r;
    one = (SAT_W+1)'(1);
    sum = {a[SAT_W-1], a} + {b[SAT_W-1], b};
    hi  = (one <<< (w - 1)) - one;
    lo  = -(one <<< (w - 1));
    r.clipped = 1'b1;
    if (sum > hi) begin
      r.val = hi[SAT_W-1:0];
    end else if (sum < lo) begin
      r.val = lo[SAT_W-1:0];
    end else begin
      r.val     = sum[SAT_W-1:0];
      r.clipped = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/pod_fx_scale.sv
// -----------------------------------------------------------------------------
// pod_fx_scale
// Registered fixed-point timestep scaling: y = (x * DT_NUM) >>> DT_SHIFT.
// The product is kept at full DATA_W+32 bit precision; the arithmetic shift
// truncates toward -inf. Result is registered (one cycle latency), no reset
// since it is pure datapath.
//
// Ports:
//   clk_i  in   1       clock
//   x_i    in   DATA_W  signed operand
//   y_o    out  DATA_W  signed scaled result, registered
// -----------------------------------------------------------------------------
module pod_fx_scale
  import pod_model_pkg::*;
#(
  parameter int          DATA_W   = DATA_W_DEF,
  parameter int unsigned DT_NUM   = 21475,
  parameter int unsigned DT_SHIFT = 32
) (
  input  logic                     clk_i,
  input  logic signed [DATA_W-1:0] x_i,
  output logic signed [DATA_W-1:0] y_o
);

  localparam int PROD_W = DATA_W + 32;
  localparam logic signed [PROD_W-1:0] K = PROD_W'(DT_NUM);

  logic signed [PROD_W-1:0] prod;
  logic signed [PROD_W-1:0] shifted;
  logic                     unused_hi;

  always_comb begin
    prod    = PROD_W'(x_i) * K;
    shifted = prod >>> DT_SHIFT;
  end

  // Upper product bits only matter if DT_NUM exceeds 2^DT_SHIFT, which the
  // model never configures; they are dropped.
  assign unused_hi = ^shifted[PROD_W-1:DATA_W];

  always_ff @(posedge clk_i) begin
    y_o <= shifted[DATA_W-1:0];
  end

endmodule

// File: rtl/pod_kinematics_integrator.sv
// -----------------------------------------------------------------------------
// pod_kinematics_integrator
// Single-axis pod dynamics model. Each accepted acceleration sample is
// integrated with semi-implicit Euler:
//   v_new = sat(v + a*dt);  p_new = sat(p + v_new*dt)
// followed by track-end / track-start clamping. One shared scaler performs
// both multiplies; a sample takes 5 cycles (IDLE, MUL_V, ADD_V, MUL_P, ADD_P).
//
// Each state names the result held in registers during that state:
//   MUL_V  dv  sits in the scaler register
//   ADD_V  v_new sits in vnew_q
//   MUL_P  dp  sits in the scaler register
//   ADD_P  position / velocity committed, out_valid high
//
// Ports:
//   clk_200khz   in   1       system clock
//   rst          in   1       synchronous active-high reset
//   accel_valid  in   1       sample offered
//   accel_ready  out  1       sample can be accepted (IDLE and no load)
//   accel        in   DATA_W  signed acceleration
//   run_en       in   1       1 integrate, 0 freeze (sampled at accept)
//   load         in   1       strobe: load position / velocity, abort sample
//   load_pos     in   DATA_W  position loaded on load
//   load_vel     in   DATA_W  velocity loaded on load
//   position     out  DATA_W  registered position
//   velocity     out  DATA_W  registered velocity
//   out_valid    out  1       one-cycle pulse when a sample is committed
//   sat_flag     out  1       sticky: a result was clipped
//   at_end       out  1       sticky: position reached TRACK_LEN
// -----------------------------------------------------------------------------
module pod_kinematics_integrator
  import pod_model_pkg::*;
#(
  parameter int                DATA_W    = DATA_W_DEF,
  parameter int                FRAC_W    = FRAC_W_DEF,
  parameter int unsigned       DT_NUM    = 21475,
  parameter int unsigned       DT_SHIFT  = 32,
  parameter logic [DATA_W-1:0] TRACK_LEN = DATA_W'(32'h0640_0000)
) (
  input  logic                     clk_200khz,
  input  logic                     rst,
  input  logic                     accel_valid,
  output logic                     accel_ready,
  input  logic signed [DATA_W-1:0] accel,
  input  logic                     run_en,
  input  logic                     load,
  input  logic signed [DATA_W-1:0] load_pos,
  input  logic signed [DATA_W-1:0] load_vel,
  output logic signed [DATA_W-1:0] position,
  output logic signed [DATA_W-1:0] velocity,
  output logic                     out_valid,
  output logic                     sat_flag,
  output logic                     at_end
);

  localparam logic signed [DATA_W-1:0] TRACK_S = TRACK_LEN;

  pod_state_e               state_q;
  logic signed [DATA_W-1:0] position_q;
  logic signed [DATA_W-1:0] velocity_q;
  logic                     out_valid_q;
  logic                     sat_q;
  logic                     at_end_q;

  logic                     run_q;
  logic signed [DATA_W-1:0] vnew_q;
  logic                     vsat_q;

  logic signed [DATA_W-1:0] scale_x;
  logic signed [DATA_W-1:0] scaled;

  sat_res_t                 v_res;
  sat_res_t                 p_res;
  logic signed [DATA_W-1:0] vnew_d;
  logic signed [DATA_W-1:0] p_sum;
  logic signed [DATA_W-1:0] pos_d;
  logic signed [DATA_W-1:0] vel_d;
  logic                     at_end_d;
  logic                     sat_d;
  logic                     unused_bits;

  // Accept only in IDLE; a simultaneous load takes priority over the sample.
  assign accel_ready = (state_q == IDLE) && !load && !rst;

  // Shared scaler: in IDLE it is fed the incoming sample so dv is ready in
  // MUL_V; otherwise it is fed v_new so dp is ready in MUL_P.
  assign scale_x = (state_q == IDLE) ? accel : vnew_q;

  pod_fx_scale #(
    .DATA_W  (DATA_W),
    .DT_NUM  (DT_NUM),
    .DT_SHIFT(DT_SHIFT)
  ) u_scale (
    .clk_i(clk_200khz),
    .x_i  (scale_x),
    .y_o  (scaled)
  );

  always_comb begin
    // Velocity step, consumed while in MUL_V (scaled = dv).
    v_res  = sat_add(SAT_W'(velocity_q), SAT_W'(scaled), DATA_W);
    vnew_d = v_res.val[DATA_W-1:0];
    // Parked at the track end: the pod may only move backwards. Forcing
    // v_new here also makes dp zero, so position stays at TRACK_LEN.
    if (at_end_q && !vnew_d[DATA_W-1] && (vnew_d != '0)) begin
      vnew_d = '0;
    end

    // Position step, consumed while in MUL_P (scaled = dp).
    p_res    = sat_add(SAT_W'(position_q), SAT_W'(scaled), DATA_W);
    p_sum    = p_res.val[DATA_W-1:0];
    pos_d    = p_sum;
    vel_d    = vnew_q;
    at_end_d = at_end_q;
    if (p_sum >= TRACK_S) begin
      pos_d    = TRACK_S;
      vel_d    = '0;
      at_end_d = 1'b1;
    end else if (p_sum[DATA_W-1]) begin
      pos_d = '0;
      if (vnew_q[DATA_W-1]) begin
        vel_d = '0;
      end
    end
    sat_d = sat_q | vsat_q | p_res.clipped;
  end

  assign unused_bits = ^{v_res.val[SAT_W-1:DATA_W], p_res.val[SAT_W-1:DATA_W], 32'(FRAC_W)};

  // Datapath holding registers, no reset needed.
  always_ff @(posedge clk_200khz) begin
    if (state_q == IDLE) begin
      run_q <= run_en;
    end
    if (state_q == MUL_V) begin
      vnew_q <= vnew_d;
      vsat_q <= v_res.clipped;
    end
  end

  // Sequencer with registered outputs.
  always_ff @(posedge clk_200khz) begin
    if (rst) begin
      state_q     <= IDLE;
      position_q  <= '0;
      velocity_q  <= '0;
      out_valid_q <= 1'b0;
      sat_q       <= 1'b0;
      at_end_q    <= 1'b0;
    end else if (load) begin
      state_q     <= IDLE;
      position_q  <= load_pos;
      velocity_q  <= load_vel;
      out_valid_q <= 1'b0;
      sat_q       <= 1'b0;
      at_end_q    <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accel_valid && accel_ready) begin
            state_q <= MUL_V;
          end
        end
        MUL_V: state_q <= ADD_V;
        ADD_V: state_q <= MUL_P;
        MUL_P: begin
          state_q     <= ADD_P;
          out_valid_q <= 1'b1;
          // Frozen samples still pulse out_valid but leave state and flags.
          if (run_q) begin
            position_q <= pos_d;
            velocity_q <= vel_d;
            at_end_q   <= at_end_d;
            sat_q      <= sat_d;
          end
        end
        ADD_P:   state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign position  = position_q;
  assign velocity  = velocity_q;
  assign out_valid = out_valid_q;
  assign sat_flag  = sat_q;
  assign at_end    = at_end_q;

endmodule

// File: tb/tb_pod_kinematics_integrator.sv
// -----------------------------------------------------------------------------
// tb_pod_kinematics_integrator
// Directed bench for pod_kinematics_integrator with dt = 1/16 s
// (DT_NUM = 1, DT_SHIFT = 4). Expected values are hand-computed.
// -----------------------------------------------------------------------------
module tb_pod_kinematics_integrator;

  localparam logic [31:0] TL = 32'h0640_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        accel_valid;
  logic        accel_ready;
  logic [31:0] accel;
  logic        run_en;
  logic        load;
  logic [31:0] load_pos;
  logic [31:0] load_vel;
  logic [31:0] position;
  logic [31:0] velocity;
  logic        out_valid;
  logic        sat_flag;
  logic        at_end;

  int nvec = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  pod_kinematics_integrator #(
    .DATA_W   (32),
    .FRAC_W   (16),
    .DT_NUM   (1),
    .DT_SHIFT (4),
    .TRACK_LEN(32'h0640_0000)
  ) dut (
    .clk_200khz (clk),
    .rst        (rst),
    .accel_valid(accel_valid),
    .accel_ready(accel_ready),
    .accel      (accel),
    .run_en     (run_en),
    .load       (load),
    .load_pos   (load_pos),
    .load_vel   (load_vel),
    .position   (position),
    .velocity   (velocity),
    .out_valid  (out_valid),
    .sat_flag   (sat_flag),
    .at_end     (at_end)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [31:0] p, input logic [31:0] v);
    load_pos = p;
    load_vel = v;
    load     = 1'b1;
    tick();
    load = 1'b0;
    #1;
  endtask

  // Offers one sample, waits (bounded) for acceptance, then returns at the
  // cycle out_valid is seen. lat = cycles from accept to out_valid, -1 if none.
  task automatic apply_sample(input logic [31:0] a, input logic run, output int lat);
    int w;
    w   = 0;
    lat = -1;
    accel       = a;
    run_en      = run;
    accel_valid = 1'b1;
    #1;
    while (!accel_ready && w < 20) begin
      tick();
      w++;
    end
    if (!accel_ready) begin
      accel_valid = 1'b0;
      return;
    end
    tick();
    accel_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if (out_valid) begin
        lat = k;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    logic [99:0] got;
    rst = 1'b1; load = 1'b0; run_en = 1'b1;
    accel_valid = 1'b1; accel = 32'h0010_0000;
    load_pos = '0; load_vel = '0;
    tick();
    tick();
    got = {position, velocity, out_valid, sat_flag, at_end, accel_ready};
    nvec++;
    if (got !== 100'd0) begin
      nfail++;
      $display("FAIL reset_outputs: got %h want 0", got);
    end
    rst = 1'b0;
    accel_valid = 1'b0;
    #1;
    nvec++;
    if (accel_ready !== 1'b1) begin
      nfail++;
      $display("FAIL reset_idle_ready: got %b want 1", accel_ready);
    end
  endtask

  task automatic test_single();
    logic [3:0] ov_seen;
    logic [3:0] rdy_seen;
    accel = 32'h0010_0000; run_en = 1'b1; accel_valid = 1'b1;
    #1;
    nvec++;
    if (accel_ready !== 1'b1) begin
      nfail++;
      $display("FAIL single_ready_n: got %b want 1", accel_ready);
    end
    tick();
    accel_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      ov_seen[k-1]  = out_valid;
      rdy_seen[k-1] = accel_ready;
      if (k < 4) tick();
    end
    nvec++;
    if (ov_seen !== 4'b1000) begin
      nfail++;
      $display("FAIL single_out_valid_timing: got %b want 1000", ov_seen);
    end
    nvec++;
    if (rdy_seen !== 4'b0000) begin
      nfail++;
      $display("FAIL single_ready_busy: got %b want 0000", rdy_seen);
    end
    nvec++;
    if (velocity !== 32'h0001_0000) begin
      nfail++;
      $display("FAIL single_velocity: got %h want 00010000", velocity);
    end
    nvec++;
    if (position !== 32'h0000_1000) begin
      nfail++;
      $display("FAIL single_position: got %h want 00001000", position);
    end
    tick();
    nvec++;
    if ({out_valid, accel_ready} !== 2'b01) begin
      nfail++;
      $display("FAIL single_n5: got ov/rdy %b want 01", {out_valid, accel_ready});
    end
  endtask

  task automatic test_back_to_back();
    int acc[3];
    int ovc[3];
    logic [31:0] vv[3];
    logic [31:0] pp[3];
    int na;
    int no;
    int exp_acc[3] = '{0, 5, 10};
    int exp_ovc[3] = '{4, 9, 14};
    logic [31:0] exp_v[3] = '{32'h0001_0000, 32'h0002_0000, 32'h0003_0000};
    logic [31:0] exp_p[3] = '{32'h0000_1000, 32'h0000_3000, 32'h0000_6000};
    na = 0;
    no = 0;
    do_load(32'h0, 32'h0);
    accel = 32'h0010_0000; run_en = 1'b1; accel_valid = 1'b1;
    #1;
    for (int c = 0; c < 15; c++) begin
      if (accel_ready && accel_valid && na < 3) begin
        acc[na] = c;
        na++;
      end
      tick();
      if (na == 3) accel_valid = 1'b0;
      if (out_valid && no < 3) begin
        ovc[no] = c + 1;
        vv[no]  = velocity;
        pp[no]  = position;
        no++;
      end
    end
    accel_valid = 1'b0;
    nvec++;
    if (na !== 3 || no !== 3) begin
      nfail++;
      $display("FAIL b2b_counts: got accepts %0d outputs %0d want 3 3", na, no);
    end else begin
      for (int i = 0; i < 3; i++) begin
        nvec++;
        if (acc[i] !== exp_acc[i] || ovc[i] !== exp_ovc[i]) begin
          nfail++;
          $display("FAIL b2b_timing[%0d]: got accept %0d valid %0d want %0d %0d",
                   i, acc[i], ovc[i], exp_acc[i], exp_ovc[i]);
        end
        nvec++;
        if (vv[i] !== exp_v[i] || pp[i] !== exp_p[i]) begin
          nfail++;
          $display("FAIL b2b_state[%0d]: got v %h p %h want v %h p %h",
                   i, vv[i], pp[i], exp_v[i], exp_p[i]);
        end
      end
    end
  endtask

  task automatic test_track_end();
    int lat;
    do_load(32'h063F_F000, 32'h0010_0000);
    apply_sample(32'h0, 1'b1, lat);
    nvec++;
    if (lat !== 4 || position !== TL || velocity !== 32'h0 || at_end !== 1'b1) begin
      nfail++;
      $display("FAIL end_clamp: got lat %0d p %h v %h end %b want 4 %h 0 1",
               lat, position, velocity, at_end, TL);
    end
    apply_sample(32'h0010_0000, 1'b1, lat);
    nvec++;
    if (lat !== 4 || position !== TL || velocity !== 32'h0 || at_end !== 1'b1) begin
      nfail++;
      $display("FAIL end_hold: got lat %0d p %h v %h end %b want 4 %h 0 1",
               lat, position, velocity, at_end, TL);
    end
  endtask

  task automatic test_saturation();
    int lat;
    do_load(32'hFC00_0000, 32'h7FFF_FFF0);
    apply_sample(32'h7FFF_0000, 1'b1, lat);
    nvec++;
    if (lat !== 4 || velocity !== 32'h7FFF_FFFF || position !== 32'h03FF_FFFF) begin
      nfail++;
      $display("FAIL sat_values: got lat %0d v %h p %h want 4 7fffffff 03ffffff",
               lat, velocity, position);
    end
    nvec++;
    if ({sat_flag, at_end} !== 2'b10) begin
      nfail++;
      $display("FAIL sat_flags: got sat/end %b want 10", {sat_flag, at_end});
    end
    // A load clears the sticky flag; loaded values are taken unclamped.
    do_load(32'h0700_0000, 32'hFFFF_0000);
    nvec++;
    if ({sat_flag, at_end} !== 2'b00 || position !== 32'h0700_0000) begin
      nfail++;
      $display("FAIL sat_load_clear: got sat/end %b p %h want 00 07000000",
               {sat_flag, at_end}, position);
    end
  endtask

  task automatic test_start_clamp();
    int lat;
    do_load(32'h0000_0100, 32'hFFFF_0000);
    apply_sample(32'h0, 1'b1, lat);
    nvec++;
    if (lat !== 4 || position !== 32'h0 || velocity !== 32'h0 || at_end !== 1'b0) begin
      nfail++;
      $display("FAIL start_clamp: got lat %0d p %h v %h end %b want 4 0 0 0",
               lat, position, velocity, at_end);
    end
  endtask

  task automatic test_floor_rounding();
    int lat;
    do_load(32'h0010_0000, 32'h0);
    apply_sample(32'hFFFF_FFFF, 1'b1, lat);
    nvec++;
    if (lat !== 4 || velocity !== 32'hFFFF_FFFF || position !== 32'h000F_FFFF) begin
      nfail++;
      $display("FAIL floor_round: got lat %0d v %h p %h want 4 ffffffff 000fffff",
               lat, velocity, position);
    end
  endtask

  task automatic test_freeze();
    int lat;
    do_load(32'h0001_2345, 32'h0002_0000);
    apply_sample(32'h0010_0000, 1'b0, lat);
    nvec++;
    if (lat !== 4 || position !== 32'h0001_2345 || velocity !== 32'h0002_0000) begin
      nfail++;
      $display("FAIL freeze_hold: got lat %0d p %h v %h want 4 00012345 00020000",
               lat, position, velocity);
    end
    do_load(32'h0, 32'h7FFF_FFF0);
    apply_sample(32'h7FFF_0000, 1'b0, lat);
    nvec++;
    if (lat !== 4 || velocity !== 32'h7FFF_FFF0 || sat_flag !== 1'b0) begin
      nfail++;
      $display("FAIL freeze_no_flag: got lat %0d v %h sat %b want 4 7ffffff0 0",
               lat, velocity, sat_flag);
    end
  endtask

  task automatic test_load_abort();
    int pulses;
    pulses = 0;
    do_load(32'h0, 32'h0);
    accel = 32'h0010_0000; run_en = 1'b1; accel_valid = 1'b1;
    #1;
    nvec++;
    if (accel_ready !== 1'b1) begin
      nfail++;
      $display("FAIL abort_ready: got %b want 1", accel_ready);
    end
    tick();                        // N+1 MUL_V
    accel_valid = 1'b0;
    tick();                        // N+2 ADD_V
    tick();                        // N+3 MUL_P
    load_pos = 32'h0000_ABCD;
    load_vel = 32'h0000_1234;
    load     = 1'b1;
    tick();                        // N+4
    load = 1'b0;
    #1;
    nvec++;
    if (out_valid !== 1'b0 || position !== 32'h0000_ABCD ||
        velocity !== 32'h0000_1234 || accel_ready !== 1'b1) begin
      nfail++;
      $display("FAIL load_abort: got ov %b p %h v %h rdy %b want 0 0000abcd 00001234 1",
               out_valid, position, velocity, accel_ready);
    end
    for (int k = 0; k < 6; k++) begin
      tick();
      if (out_valid) pulses++;
    end
    nvec++;
    if (pulses !== 0) begin
      nfail++;
      $display("FAIL load_abort_no_valid: got %0d pulses want 0", pulses);
    end
  endtask

  task automatic test_reset_abort();
    logic [99:0] got;
    int pulses;
    pulses = 0;
    do_load(32'h0000_5555, 32'h0001_0000);
    accel = 32'h0010_0000; run_en = 1'b1; accel_valid = 1'b1;
    #1;
    tick();                        // N+1 MUL_V
    accel_valid = 1'b0;
    tick();                        // N+2 ADD_V
    rst = 1'b1;
    tick();                        // N+3
    got = {position, velocity, out_valid, sat_flag, at_end, accel_ready};
    nvec++;
    if (got !== 100'd0) begin
      nfail++;
      $display("FAIL reset_abort_outputs: got %h want 0", got);
    end
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (out_valid) pulses++;
    end
    nvec++;
    if (pulses !== 0 || accel_ready !== 1'b1) begin
      nfail++;
      $display("FAIL reset_abort_after: got pulses %0d rdy %b want 0 1", pulses, accel_ready);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_track_end();
    test_saturation();
    test_start_clamp();
    test_floor_rounding();
    test_freeze();
    test_load_abort();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
